// File: rtl/pe_flit_injector.sv
// PE-side flit transmitter: payload FIFO plus head/body/tail packetiser released under grant.
// Optional build macro INJ_TIMEOUT_EN adds a head-grant watchdog that drops the packet.
module pe_flit_injector #(
    parameter logic [3:0] ADDRESS     = 4'b1111,
    parameter int         DEPTH       = 16,
    parameter int         PTR_W       = 4,
    parameter int         TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             wr_en,
    input  logic [29:0]      wr_data,
    output logic             fifo_full,
    output logic [PTR_W:0]   fifo_count,
    output logic             overflow,
    input  logic             cmd_valid,
    input  logic [3:0]       cmd_dest,
    input  logic [5:0]       cmd_len,
    output logic             cmd_ready,
    output logic [31:0]      flit_out,
    output logic [2:0]       gate_out,
    output logic [3:0]       source_out,
    output logic [1:0]       handshake_check,
    input  logic             grant,
    output logic             pkt_done,
    output logic             error
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_HEAD     = 2'd1;
    localparam logic [1:0] S_BODY     = 2'd2;
    localparam logic [1:0] S_WAIT_END = 2'd3;

    localparam logic [1:0] T_HEAD   = 2'b00;
    localparam logic [1:0] T_BODY   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    localparam logic [1:0] HS_IDLE = 2'b00;
    localparam logic [1:0] HS_FLIT = 2'b01;
    localparam logic [1:0] HS_LAST = 2'b10;

    localparam logic [2:0] GATE_PE = 3'd4;
    localparam int         CW      = (PTR_W + 1 > 6) ? PTR_W + 1 : 6;

    logic [29:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic [1:0]       state;
    logic [5:0]       remaining;
    logic             push, pop, accept, disc_active;
    logic [29:0]      head_word;

    assign head_word  = mem[rd_ptr];
    assign fifo_count = count;
    // DEPTH is a power of two, so the count MSB alone marks full
    assign fifo_full  = count[PTR_W];
    assign cmd_ready  = (state == S_IDLE) && !disc_active && (CW'(count) >= CW'(cmd_len));
    assign accept     = enable && cmd_valid && cmd_ready;

`ifdef INJ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;
    logic [5:0]      disc_cnt;
    logic            error_q;
    assign disc_active = (disc_cnt != 6'd0);
    assign error       = error_q;
`else
    assign disc_active = 1'b0;
    assign error       = 1'b0;
`endif

    always_comb begin
        pop = 1'b0;
        if (enable && count != '0) begin
            case (state)
                S_IDLE:  pop = disc_active;
                S_HEAD:  pop = grant && (remaining != 6'd0);
                S_BODY:  pop = grant && (remaining != 6'd1);
                default: pop = 1'b0;
            endcase
        end
    end

    // A pop in the same edge frees a slot, so a full FIFO still takes the push
    assign push = enable && wr_en && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (enable) begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && fifo_full && !pop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            remaining       <= '0;
            flit_out        <= '0;
            gate_out        <= '0;
            source_out      <= '0;
            handshake_check <= HS_IDLE;
            pkt_done        <= 1'b0;
`ifdef INJ_TIMEOUT_EN
            to_cnt          <= '0;
            disc_cnt        <= '0;
            error_q         <= 1'b0;
`endif
        end else if (enable) begin
            pkt_done <= 1'b0;
`ifdef INJ_TIMEOUT_EN
            error_q  <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        remaining       <= cmd_len;
                        flit_out        <= {(cmd_len == 6'd0) ? T_SINGLE : T_HEAD,
                                            cmd_dest, ADDRESS, cmd_len, 16'h0000};
                        gate_out        <= GATE_PE;
                        source_out      <= ADDRESS;
                        handshake_check <= (cmd_len == 6'd0) ? HS_LAST : HS_FLIT;
                        state           <= S_HEAD;
`ifdef INJ_TIMEOUT_EN
                        to_cnt          <= '0;
                    end else if (disc_active) begin
                        disc_cnt        <= disc_cnt - 1'b1;
`endif
                    end
                end
                S_HEAD: begin
                    if (grant) begin
                        if (remaining == 6'd0) begin
                            pkt_done        <= 1'b1;
                            flit_out        <= '0;
                            gate_out        <= '0;
                            source_out      <= '0;
                            handshake_check <= HS_IDLE;
                            state           <= S_IDLE;
                        end else begin
                            flit_out        <= {(remaining > 6'd1) ? T_BODY : T_TAIL, head_word};
                            handshake_check <= (remaining > 6'd1) ? HS_FLIT : HS_LAST;
                            state           <= S_BODY;
                        end
`ifdef INJ_TIMEOUT_EN
                    end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        // Head withdrawn; its reserved payload is drained from IDLE
                        error_q         <= 1'b1;
                        disc_cnt        <= remaining;
                        flit_out        <= '0;
                        gate_out        <= '0;
                        source_out      <= '0;
                        handshake_check <= HS_IDLE;
                        state           <= S_IDLE;
                    end else begin
                        to_cnt          <= to_cnt + 1'b1;
`endif
                    end
                end
                S_BODY: begin
                    if (grant) begin
                        if (remaining == 6'd1) begin
                            pkt_done        <= 1'b1;
                            flit_out        <= '0;
                            gate_out        <= '0;
                            source_out      <= '0;
                            handshake_check <= HS_IDLE;
                            state           <= S_IDLE;
                        end else begin
                            remaining       <= remaining - 1'b1;
                            flit_out        <= {(remaining > 6'd2) ? T_BODY : T_TAIL, head_word};
                            handshake_check <= (remaining > 6'd2) ? HS_FLIT : HS_LAST;
                        end
                    end
                end
                S_WAIT_END: begin
                    state           <= S_IDLE;
                    flit_out        <= '0;
                    gate_out        <= '0;
                    source_out      <= '0;
                    handshake_check <= HS_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_flit_injector.sv
// Directed vector bench for pe_flit_injector: table of per-cycle records plus corner sequences.
module tb_pe_flit_injector;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        wr_en;
    logic [29:0] wr_data;
    logic        fifo_full;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic        cmd_valid;
    logic [3:0]  cmd_dest;
    logic [5:0]  cmd_len;
    logic        cmd_ready;
    logic [31:0] flit_out;
    logic [2:0]  gate_out;
    logic [3:0]  source_out;
    logic [1:0]  handshake_check;
    logic        grant;
    logic        pkt_done;
    logic        error;

    int checks   = 0;
    int failures = 0;

    pe_flit_injector #(.ADDRESS(4'hF), .DEPTH(16), .PTR_W(4), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .wr_en(wr_en), .wr_data(wr_data),
        .fifo_full(fifo_full), .fifo_count(fifo_count), .overflow(overflow),
        .cmd_valid(cmd_valid), .cmd_dest(cmd_dest), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
        .flit_out(flit_out), .gate_out(gate_out), .source_out(source_out),
        .handshake_check(handshake_check), .grant(grant),
        .pkt_done(pkt_done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [29:0] wd;
        logic        cv;
        logic [3:0]  dst;
        logic [5:0]  len;
        logic        gnt;
        logic        rdy;
        logic [31:0] flit;
        logic [1:0]  hs;
        logic [2:0]  gate;
        logic        done;
        logic [4:0]  cnt;
    } vec_t;

    vec_t vt [28];

    function automatic vec_t mk(input logic wr, input logic [29:0] wd, input logic cv,
                                input logic [3:0] dst, input logic [5:0] len, input logic gnt,
                                input logic rdy, input logic [31:0] flit, input logic [1:0] hs,
                                input logic [2:0] gate, input logic done, input logic [4:0] cnt);
        vec_t v;
        v.wr = wr; v.wd = wd; v.cv = cv; v.dst = dst; v.len = len; v.gnt = gnt;
        v.rdy = rdy; v.flit = flit; v.hs = hs; v.gate = gate; v.done = done; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_data = '0; cmd_valid = 0; cmd_dest = '0; cmd_len = '0; grant = 0;
    endtask

    initial begin
        int n;
        logic seen;
        idle_inputs();
        enable = 1;
        reset  = 0;

        // Test 1: single-flit packet; grant in IDLE ignored
        vt[0]  = mk(0, 0, 1, 4'h3, 0, 1,   1, 32'hCFC00000, 2'b10, 3'd4, 0, 0);
        vt[1]  = mk(0, 0, 0, 0,    0, 1,   0, 32'h0,        2'b00, 3'd0, 1, 0);
        vt[2]  = mk(0, 0, 0, 0,    0, 0,   1, 32'h0,        2'b00, 3'd0, 0, 0);
        // Test 2: three payload words, head held five cycles
        vt[3]  = mk(1, 1, 0, 0,    3, 0,   0, 32'h0,        2'b00, 3'd0, 0, 1);
        vt[4]  = mk(1, 2, 0, 0,    3, 0,   0, 32'h0,        2'b00, 3'd0, 0, 2);
        vt[5]  = mk(1, 3, 0, 0,    3, 0,   0, 32'h0,        2'b00, 3'd0, 0, 3);
        vt[6]  = mk(0, 0, 1, 4'h5, 3, 0,   1, 32'h17C30000, 2'b01, 3'd4, 0, 3);
        for (int i = 7; i < 12; i++)
            vt[i] = mk(0, 0, 0, 0, 0, 0,   0, 32'h17C30000, 2'b01, 3'd4, 0, 3);
        vt[12] = mk(0, 0, 0, 0,    0, 1,   0, 32'h40000001, 2'b01, 3'd4, 0, 2);
        vt[13] = mk(0, 0, 0, 0,    0, 1,   0, 32'h40000002, 2'b01, 3'd4, 0, 1);
        vt[14] = mk(0, 0, 0, 0,    0, 1,   0, 32'h80000003, 2'b10, 3'd4, 0, 0);
        vt[15] = mk(0, 0, 0, 0,    0, 1,   0, 32'h0,        2'b00, 3'd0, 1, 0);
        // Test 4: cmd_ready waits for enough words
        vt[16] = mk(1, 30'hA, 0, 0, 4, 0,  0, 32'h0,        2'b00, 3'd0, 0, 1);
        vt[17] = mk(1, 30'hB, 0, 0, 4, 0,  0, 32'h0,        2'b00, 3'd0, 0, 2);
        vt[18] = mk(0, 0,     0, 0, 4, 0,  0, 32'h0,        2'b00, 3'd0, 0, 2);
        vt[19] = mk(1, 30'hC, 0, 0, 4, 0,  0, 32'h0,        2'b00, 3'd0, 0, 3);
        vt[20] = mk(1, 30'hD, 0, 0, 4, 0,  0, 32'h0,        2'b00, 3'd0, 0, 4);
        vt[21] = mk(0, 0,     0, 0, 4, 0,  1, 32'h0,        2'b00, 3'd0, 0, 4);
        vt[22] = mk(0, 0, 1, 4'hA, 4, 1,   1, 32'h2BC40000, 2'b01, 3'd4, 0, 4);
        vt[23] = mk(0, 0, 0, 0,    0, 1,   0, 32'h4000000A, 2'b01, 3'd4, 0, 3);
        vt[24] = mk(0, 0, 0, 0,    0, 1,   0, 32'h4000000B, 2'b01, 3'd4, 0, 2);
        vt[25] = mk(0, 0, 0, 0,    0, 1,   0, 32'h4000000C, 2'b01, 3'd4, 0, 1);
        vt[26] = mk(0, 0, 0, 0,    0, 1,   0, 32'h8000000D, 2'b10, 3'd4, 0, 0);
        vt[27] = mk(0, 0, 0, 0,    0, 1,   0, 32'h0,        2'b00, 3'd0, 1, 0);

        repeat (2) @(negedge clk);
        chk("rst_flit", flit_out, 0);
        chk("rst_hs", 32'(handshake_check), 0);
        chk("rst_gate", 32'(gate_out), 0);
        chk("rst_src", 32'(source_out), 0);
        chk("rst_cnt", 32'(fifo_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_done", 32'(pkt_done), 0);
        chk("rst_err", 32'(error), 0);
        reset = 1;

        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            wr_en = vt[i].wr; wr_data = vt[i].wd; cmd_valid = vt[i].cv;
            cmd_dest = vt[i].dst; cmd_len = vt[i].len; grant = vt[i].gnt;
            #1;
            chk($sformatf("v%0d_rdy", i), 32'(cmd_ready), 32'(vt[i].rdy));
            @(posedge clk); #1;
            chk($sformatf("v%0d_flit", i), flit_out, vt[i].flit);
            chk($sformatf("v%0d_hs", i), 32'(handshake_check), 32'(vt[i].hs));
            chk($sformatf("v%0d_gate", i), 32'(gate_out), 32'(vt[i].gate));
            chk($sformatf("v%0d_src", i), 32'(source_out), (vt[i].gate != 0) ? 32'hF : 32'h0);
            chk($sformatf("v%0d_done", i), 32'(pkt_done), 32'(vt[i].done));
            chk($sformatf("v%0d_cnt", i), 32'(fifo_count), 32'(vt[i].cnt));
        end

        // enable=0 freezes: command and push ignored
        @(negedge clk);
        idle_inputs();
        enable = 0; cmd_valid = 1; wr_en = 1; wr_data = 30'h7;
        @(posedge clk); #1;
        chk("frz_gate", 32'(gate_out), 0);
        chk("frz_cnt", 32'(fifo_count), 0);
        @(negedge clk);
        idle_inputs();
        enable = 1;

        // Test 3: fill, overflow, length limit, push+pop while full
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wr_en = 1; wr_data = 30'(i + 1);
        end
        @(negedge clk);
        wr_en = 0; #1;
        chk("full_flag", 32'(fifo_full), 1);
        chk("full_cnt", 32'(fifo_count), 16);
        chk("full_ovf0", 32'(overflow), 0);
        @(negedge clk);
        wr_en = 1; wr_data = 30'h3FF;
        @(posedge clk); #1;
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_cnt", 32'(fifo_count), 16);
        @(negedge clk);
        wr_en = 0; cmd_len = 17; #1;
        chk("len17_rdy", 32'(cmd_ready), 0);
        cmd_len = 16; #1;
        chk("len16_rdy", 32'(cmd_ready), 1);
        cmd_valid = 1; cmd_dest = 4'h2; cmd_len = 1;
        @(posedge clk); #1;
        chk("fp_head", flit_out, 32'h0BC10000);
        @(negedge clk);
        cmd_valid = 0; grant = 1; wr_en = 1; wr_data = 30'h55;
        @(posedge clk); #1;
        chk("fp_tail", flit_out, 32'h80000001);
        chk("fp_tail_hs", 32'(handshake_check), 2);
        chk("fp_cnt", 32'(fifo_count), 16);
        chk("fp_full", 32'(fifo_full), 1);
        @(negedge clk);
        wr_en = 0;
        @(posedge clk); #1;
        chk("fp_done", 32'(pkt_done), 1);
        @(negedge clk);
        idle_inputs();

        // Test 5: reset during the second body flit
        cmd_valid = 1; cmd_dest = 4'h1; cmd_len = 3; grant = 1;
        @(posedge clk); #1;
        chk("ab_head", flit_out, 32'h07C30000);
        @(negedge clk);
        cmd_valid = 0; cmd_len = 0;
        @(posedge clk); #1;
        chk("ab_body1", flit_out, 32'h40000002);
        @(posedge clk); #1;
        chk("ab_body2", flit_out, 32'h40000003);
        #2;
        grant = 0;
        reset = 0; #1;
        chk("ab_flit", flit_out, 0);
        chk("ab_hs", 32'(handshake_check), 0);
        chk("ab_gate", 32'(gate_out), 0);
        chk("ab_src", 32'(source_out), 0);
        chk("ab_cnt", 32'(fifo_count), 0);
        chk("ab_ovf", 32'(overflow), 0);
        chk("ab_rdy", 32'(cmd_ready), 1);
        @(negedge clk);
        reset = 1;

`ifdef INJ_TIMEOUT_EN
        // Test 6: head never granted
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            wr_en = 1; wr_data = 30'(i + 8);
        end
        @(negedge clk);
        wr_en = 0; cmd_valid = 1; cmd_dest = 4'h6; cmd_len = 2;
        @(posedge clk); #1;
        @(negedge clk);
        cmd_valid = 0;
        seen = 0;
        n = 0;
        while (!seen && n < 200) begin
            @(posedge clk); #1;
            n++;
            seen = error;
        end
        chk("to_seen", 32'(seen), 1);
        chk("to_cycles", n, 64);
        chk("to_hs", 32'(handshake_check), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("to_cnt", 32'(fifo_count), 0);
        chk("to_err_pulse", 32'(error), 0);
        chk("to_rdy", 32'(cmd_ready), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
